// File: rtl/decoder_if.sv
// Instruction-decoder bus: raw instruction in, registered decoded fields out.
interface decoder_if;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [4:0]  opcode;
  logic        addressing_mode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [3:0]  data_mem;
  logic [5:0]  instruction_mem;
  logic [2:0]  s_r_amount;
  logic        out_valid;
  logic        illegal_op;

  modport master (
    output instr_valid, instruction,
    input  opcode, addressing_mode, rd, rs1, rs2, data_mem, instruction_mem, s_r_amount,
    input  out_valid, illegal_op
  );

  modport slave (
    input  instr_valid, instruction,
    output opcode, addressing_mode, rd, rs1, rs2, data_mem, instruction_mem, s_r_amount,
    output out_valid, illegal_op
  );
endinterface

// File: rtl/decoder.sv
// 16-bit instruction decoder with one-cycle registered outputs.
// Define DECODER_ILLEGAL_CHECK_EN to flag reserved opcodes 0x1C-0x1E on illegal_op.
module decoder (
  input logic      clk,
  input logic      rst,
  decoder_if.slave bus
);

  logic [4:0] raw_op;
  assign raw_op = bus.instruction[15:11];

  logic [4:0] opcode_d, opcode_q;
  logic       am_d, am_q;
  logic [2:0] rd_d, rd_q;
  logic [2:0] rs1_d, rs1_q;
  logic [2:0] rs2_d, rs2_q;
  logic [3:0] dmem_d, dmem_q;
  logic [5:0] imem_d, imem_q;
  logic [2:0] sra_d, sra_q;
  logic       valid_q;
`ifdef DECODER_ILLEGAL_CHECK_EN
  logic       illegal_d, illegal_q;
`endif

  // Fields not used by an instruction class are forced to zero.
  always_comb begin
    opcode_d = raw_op;
    am_d     = 1'b0;
    rd_d     = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    dmem_d   = '0;
    imem_d   = '0;
    sra_d    = '0;
`ifdef DECODER_ILLEGAL_CHECK_EN
    illegal_d = 1'b0;
`endif
    if (raw_op inside {[5'h01:5'h0F]}) begin
      am_d  = bus.instruction[10];
      rd_d  = bus.instruction[9:7];
      rs1_d = bus.instruction[6:4];
      rs2_d = bus.instruction[3:1];
    end else if (raw_op inside {[5'h10:5'h13]}) begin
      am_d  = bus.instruction[10];
      rd_d  = bus.instruction[9:7];
      rs1_d = bus.instruction[6:4];
      sra_d = bus.instruction[2:0];
    end else if (raw_op inside {5'h14, 5'h15}) begin
      am_d   = bus.instruction[10];
      rd_d   = bus.instruction[9:7];
      dmem_d = bus.instruction[3:0];
      // Base register only matters for register-indirect access.
      rs1_d  = bus.instruction[10] ? bus.instruction[6:4] : 3'b000;
    end else if (raw_op inside {[5'h16:5'h1B]}) begin
      imem_d = bus.instruction[5:0];
    end else if (raw_op inside {[5'h1C:5'h1E]}) begin
`ifdef DECODER_ILLEGAL_CHECK_EN
      illegal_d = 1'b1;
`else
      opcode_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      am_q     <= 1'b0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      dmem_q   <= '0;
      imem_q   <= '0;
      sra_q    <= '0;
      valid_q  <= 1'b0;
`ifdef DECODER_ILLEGAL_CHECK_EN
      illegal_q <= 1'b0;
`endif
    end else if (bus.instr_valid) begin
      opcode_q <= opcode_d;
      am_q     <= am_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      dmem_q   <= dmem_d;
      imem_q   <= imem_d;
      sra_q    <= sra_d;
      valid_q  <= 1'b1;
`ifdef DECODER_ILLEGAL_CHECK_EN
      illegal_q <= illegal_d;
`endif
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.opcode          = opcode_q;
  assign bus.addressing_mode = am_q;
  assign bus.rd              = rd_q;
  assign bus.rs1             = rs1_q;
  assign bus.rs2             = rs2_q;
  assign bus.data_mem        = dmem_q;
  assign bus.instruction_mem = imem_q;
  assign bus.s_r_amount      = sra_q;
  assign bus.out_valid       = valid_q;
`ifdef DECODER_ILLEGAL_CHECK_EN
  assign bus.illegal_op      = illegal_q;
`else
  assign bus.illegal_op      = 1'b0;
`endif

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: expectations queued at issue, popped one cycle later.
module tb_decoder;

  typedef struct packed {
    logic       valid;
    logic       ill;
    logic [4:0] op;
    logic       am;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] dm;
    logic [5:0] im;
    logic [2:0] sr;
  } obs_t;

  logic clk;
  logic rst;
  decoder_if bus ();

  decoder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  obs_t exp_q[$];
  obs_t last;

  // Reference model written per instruction class from the field table.
  function automatic obs_t model(input logic [15:0] w);
    obs_t       e;
    logic [4:0] op;
    op      = w[15:11];
    e       = '0;
    e.valid = 1'b1;
    e.op    = op;
    if (op == 5'd0 || op == 5'd31) begin
      // NOP / HALT: nothing else
    end else if (op <= 5'd15) begin
      e.am = w[10]; e.rd = w[9:7]; e.rs1 = w[6:4]; e.rs2 = w[3:1];
    end else if (op <= 5'd19) begin
      e.am = w[10]; e.rd = w[9:7]; e.rs1 = w[6:4]; e.sr = w[2:0];
    end else if (op <= 5'd21) begin
      e.am = w[10]; e.rd = w[9:7]; e.dm = w[3:0];
      if (w[10]) e.rs1 = w[6:4];
    end else if (op <= 5'd27) begin
      e.im = w[5:0];
    end else begin
`ifdef DECODER_ILLEGAL_CHECK_EN
      e.ill = 1'b1;
`else
      e.op = 5'd0;
`endif
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.valid = bus.out_valid;
    o.ill   = bus.illegal_op;
    o.op    = bus.opcode;
    o.am    = bus.addressing_mode;
    o.rd    = bus.rd;
    o.rs1   = bus.rs1;
    o.rs2   = bus.rs2;
    o.dm    = bus.data_mem;
    o.im    = bus.instruction_mem;
    o.sr    = bus.s_r_amount;
    return o;
  endfunction

  task automatic issue(input logic [15:0] w);
    bus.instr_valid = 1'b1;
    bus.instruction = w;
    exp_q.push_back(model(w));
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instruction = 16'h09DC;
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL reset_state: got %h required %h", got, obs_t'('0));
    else passes++;
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_first_after_reset();
    obs_t got, e;
    rst = 1'b0;
    issue(16'h8115);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    checks++;
    if (got !== e) $display("FAIL first_after_reset: got %h required %h", got, e);
    else passes++;
  endtask

  task automatic test_rtype();
    obs_t got, e, lit;
    issue(16'h09DC);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    lit = '0; lit.valid = 1'b1; lit.op = 5'b00001;
    lit.rd = 3'b011; lit.rs1 = 3'b101; lit.rs2 = 3'b110;
    checks++;
    if (got !== e) $display("FAIL rtype_model: got %h required %h", got, e);
    else passes++;
    checks++;
    if (got !== lit) $display("FAIL rtype_vector: got %h required %h", got, lit);
    else passes++;
  endtask

  task automatic test_shift();
    obs_t got, e, lit;
    issue(16'h8115);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    lit = '0; lit.valid = 1'b1; lit.op = 5'b10000;
    lit.rd = 3'b010; lit.rs1 = 3'b001; lit.sr = 3'b101;
    checks++;
    if (got !== e) $display("FAIL shift_model: got %h required %h", got, e);
    else passes++;
    checks++;
    if (got !== lit) $display("FAIL shift_vector: got %h required %h", got, lit);
    else passes++;
  endtask

  task automatic test_load_store();
    obs_t got, e, lit;
    issue(16'hA389);
    e = exp_q.pop_front();
    got = observe();
    lit = '0; lit.valid = 1'b1; lit.op = 5'b10100;
    lit.rd = 3'b111; lit.dm = 4'b1001;
    checks++;
    if (got !== lit) $display("FAIL load_direct: got %h required %h", got, lit);
    else passes++;
    // STORE register-indirect exposes rs1
    issue(16'hACB5);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    lit = '0; lit.valid = 1'b1; lit.op = 5'b10101; lit.am = 1'b1;
    lit.rd = 3'b001; lit.rs1 = 3'b011; lit.dm = 4'b0101;
    checks++;
    if (got !== lit) $display("FAIL store_indirect: got %h required %h", got, lit);
    else passes++;
  endtask

  task automatic test_jump();
    obs_t got, e, lit;
    issue(16'hB02A);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    lit = '0; lit.valid = 1'b1; lit.op = 5'b10110; lit.im = 6'b101010;
    checks++;
    if (got !== lit) $display("FAIL jump_vector: got %h required %h", got, lit);
    else passes++;
  endtask

  task automatic test_reserved();
    obs_t got, e, lit, held;
    issue(16'hE000);
    e = exp_q.pop_front();
    got = observe();
    lit = '0; lit.valid = 1'b1;
`ifdef DECODER_ILLEGAL_CHECK_EN
    lit.ill = 1'b1; lit.op = 5'b11100;
`endif
    checks++;
    if (got !== lit) $display("FAIL reserved_vector: got %h required %h", got, lit);
    else passes++;
    @(posedge clk);
    #1;
    held = lit; held.valid = 1'b0;
    got = observe();
    checks++;
    if (got !== held) $display("FAIL reserved_hold: got %h required %h", got, held);
    else passes++;
    issue(16'h09DC);
    e = exp_q.pop_front();
    got = observe();
    last = e;
    checks++;
    if (got.ill !== 1'b0 || got !== e) $display("FAIL illegal_clear: got %h required %h", got, e);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    obs_t got, e;
    words[0] = 16'h0FFF; words[1] = 16'h9C77; words[2] = 16'hF8FF; words[3] = 16'hD93F;
    for (int i = 0; i < 4; i++) begin
      issue(words[i]);
      e = exp_q.pop_front();
      got = observe();
      last = e;
      checks++;
      if (got !== e) $display("FAIL back_to_back[%0d]: got %h required %h", i, got, e);
      else passes++;
    end
    @(posedge clk);
    #1;
    e = last; e.valid = 1'b0;
    got = observe();
    checks++;
    if (got !== e) $display("FAIL idle_hold: got %h required %h", got, e);
    else passes++;
  endtask

  task automatic test_random();
    obs_t got, e;
    logic [15:0] w;
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      issue(w);
      e = exp_q.pop_front();
      got = observe();
      last = e;
      checks++;
      if (got !== e) $display("FAIL random[%0d] w=%h: got %h required %h", i, w, got, e);
      else passes++;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
        e = last; e.valid = 1'b0;
        got = observe();
        checks++;
        if (got !== e) $display("FAIL random_hold[%0d]: got %h required %h", i, got, e);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    obs_t got;
    issue(16'hB02A);
    last = exp_q.pop_front();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instruction = 16'h09DC;
    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL reset_midstream: got %h required %h", got, obs_t'('0));
    else passes++;
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL reset_then_idle: got %h required %h", got, obs_t'('0));
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d required 0", exp_q.size());
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    last = '0;
    test_reset();
    test_first_after_reset();
    test_rtype();
    test_shift();
    test_load_store();
    test_jump();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port instr_valid, input, 1 bit: instruction present this cycle.
REQ-004 SHALL have port instruction, input, 16 bits: raw instruction word.
REQ-005 SHALL have port opcode, output, 5 bits: decoded opcode.
REQ-006 SHALL have port addressing_mode, output, 1 bit: 0 = direct, 1 = register-indirect.
REQ-007 SHALL have ports rd, rs1 and rs2, each output, 3 bits: destination, source-1 and source-2 register indices.
REQ-008 SHALL have port data_mem, output, 4 bits: data-memory address.
REQ-009 SHALL have port instruction_mem, output, 6 bits: branch/jump target.
REQ-010 SHALL have port s_r_amount, output, 3 bits: shift/rotate amount.
REQ-011 SHALL have port out_valid, output, 1 bit: decoded outputs are fresh.
REQ-012 SHALL have port illegal_op, output, 1 bit: last decoded opcode is reserved.

Function
REQ-013 SHALL extract fields from instruction as follows: opcode [15:11], addressing_mode [10], rd [9:7], rs1 [6:4], rs2 [3:1], data_mem [3:0], instruction_mem [5:0], s_r_amount [2:0].
REQ-014 SHALL register all outputs: with instr_valid=1 at edge N, outputs reflect that instruction after edge N; latency is 1 cycle.
REQ-015 SHALL, with instr_valid=0 at an edge, hold all field outputs and clear out_valid.
REQ-016 SHALL set out_valid=1 for exactly one cycle per accepted instruction; back-to-back valid instructions each give one valid cycle.
REQ-017 SHALL decode opcode 0x00 (NOP) with all other field outputs zero.
REQ-018 SHALL decode opcodes 0x01-0x0F (R-type) as follows:
  - outputs: rd, rs1, rs2 and addressing_mode;
  - zero: data_mem, instruction_mem and s_r_amount.
REQ-019 SHALL decode opcodes 0x10-0x13 (shift/rotate) as follows:
  - outputs: rd, rs1, s_r_amount and addressing_mode;
  - zero: rs2, data_mem and instruction_mem.
REQ-020 SHALL decode opcodes 0x14 (LOAD) and 0x15 (STORE) as follows:
  - outputs: rd, data_mem and addressing_mode;
  - rs1 is output only when addressing_mode=1, otherwise 0;
  - zero: rs2, instruction_mem and s_r_amount.
REQ-021 SHALL decode opcodes 0x16-0x1B (jump/branch) as follows:
  - output: instruction_mem;
  - zero: rd, rs1, rs2, data_mem, s_r_amount and addressing_mode.
REQ-022 SHALL decode opcode 0x1F (HALT) like NOP.
REQ-023 SHALL output the opcode field unmodified for every legal opcode.
REQ-024 SHALL treat opcodes 0x1C-0x1E as reserved (see Configuration).

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear every output to zero, including out_valid and illegal_op.
REQ-026 SHALL give rst priority over instr_valid; an instruction presented during reset is discarded.
REQ-027 SHALL accept an instruction on the first edge with rst=0; its outputs are valid one cycle later.

Configuration
REQ-028 SHALL, with macro DECODER_ILLEGAL_CHECK_EN defined, decode reserved opcodes as follows:
  - illegal_op=1 and opcode output equal to the raw opcode;
  - all other field outputs zero;
  - illegal_op clears on the next accepted legal instruction.
REQ-029 SHALL, without DECODER_ILLEGAL_CHECK_EN, tie illegal_op to 0 and decode reserved opcodes exactly as NOP, with opcode output 0x00.

Verification
REQ-030 SHALL test R-type: 0x09DC with instr_valid=1 -> next cycle opcode=00001, rd=011, rs1=101, rs2=110, data_mem=0, instruction_mem=0, s_r_amount=0, out_valid=1.
REQ-031 SHALL test shift: 0x8115 -> opcode=10000, rd=010, rs1=001, s_r_amount=101, rs2=0.
REQ-032 SHALL test LOAD direct: 0xA389 -> opcode=10100, rd=111, data_mem=1001, rs1=0, addressing_mode=0.
REQ-033 SHALL test jump: 0xB02A -> opcode=10110, instruction_mem=101010, all register fields 0.
REQ-034 SHALL test reserved opcode: 0xE000 -> with DECODER_ILLEGAL_CHECK_EN, illegal_op=1 and opcode=11100; without it, illegal_op=0 and opcode=00000.
REQ-035 SHALL test reset mid-stream: rst=1 with instr_valid=1 and 0x09DC -> all outputs 0 next cycle; after rst=0, instr_valid=0 -> outputs hold 0 and out_valid=0.
